// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: timing widths, pixel colour width and the
// menu selection state reused by the top-level game FSM.
package vga_pkg;

  localparam int HV_W  = 11;
  localparam int RGB_B = 12;

  typedef enum logic {
    BROWSE    = 1'b0,
    CONFIRMED = 1'b1
  } menu_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between pipeline stages.
interface vga_if;
  import vga_pkg::*;

  logic [HV_W-1:0] hcount;
  logic [HV_W-1:0] vcount;
  logic            hsync;
  logic            vsync;
  logic            hblnk;
  logic            vblnk;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

// File: rtl/menu_cursor_ctl.sv
// Menu selection FSM: cursor index with wrap-around, confirm/unlock handling
// and the frame-tick driven blink phase of the cursor frame.
module menu_cursor_ctl
  import vga_pkg::*;
#(
  parameter int N_ITEMS      = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       unlock,
  input  logic       frame_tick,
  output logic [2:0] sel_idx,
  output logic       blink_on,
  output logic       confirmed,
  output logic       sel_valid
);

  localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]       IDX_LAST = 3'(N_ITEMS - 1);

  menu_state_t      r_state;
  menu_state_t      w_state_nxt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic             r_blink;
  logic             w_blink_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             w_move;
  logic             w_up;
  logic             w_down;

  // Opposing keys in the same cycle cancel each other out.
  assign w_up   = key_up & ~key_down;
  assign w_down = key_down & ~key_up;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BROWSE;
      r_idx   <= 3'd0;
      r_blink <= 1'b1;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_blink <= w_blink_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = 1'b0;
    w_move      = 1'b0;
    w_blink_nxt = r_blink;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      BROWSE: begin
        if (key_enter) begin
          w_state_nxt = CONFIRMED;
          w_valid_nxt = 1'b1;
        end else if (w_up) begin
          w_move    = 1'b1;
          w_idx_nxt = (r_idx == 3'd0) ? IDX_LAST : r_idx - 3'd1;
        end else if (w_down) begin
          w_move    = 1'b1;
          w_idx_nxt = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end
      end
      CONFIRMED: begin
        if (unlock) begin
          w_state_nxt = BROWSE;
        end
      end
    endcase

    // A move restarts the visible phase and takes priority over a frame tick.
    if (w_move) begin
      w_blink_nxt = 1'b1;
      w_cnt_nxt   = '0;
    end else if (frame_tick) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_nxt   = '0;
        w_blink_nxt = ~r_blink;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  assign sel_idx   = r_idx;
  assign blink_on  = r_blink;
  assign confirmed = (r_state == CONFIRMED);
  assign sel_valid = r_valid;

endmodule

// File: rtl/menu_cursor.sv
// VGA stage drawing a blinking frame around the highlighted menu entry and
// owning the menu selection state; pixel path latency is one clock.
module menu_cursor
  import vga_pkg::*;
#(
  parameter int              X            = 2,
  parameter int              Y            = 2,
  parameter int              ITEM_W       = 128,
  parameter int              ITEM_H       = 16,
  parameter int              ITEM_PITCH   = 32,
  parameter int              N_ITEMS      = 3,
  parameter int              BORDER       = 2,
  parameter logic [RGB_B-1:0] FRAME_COLOR  = 12'hF00,
  parameter int              BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             rst,
  vga_if.in                vga_in,
  input  logic [RGB_B-1:0] rgb_i,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_enter,
  input  logic             unlock,
  vga_if.out               vga_out,
  output logic [RGB_B-1:0] rgb_o,
  output logic [2:0]       sel_idx,
  output logic             sel_valid,
  output logic             confirmed
);

  // The frame sits outside the text box, so the origin must leave room for it.
  if (X < BORDER || Y < BORDER) begin : g_bad_origin
    $error("menu_cursor: X and Y must be >= BORDER");
  end
  if (N_ITEMS < 2 || N_ITEMS > 8) begin : g_bad_items
    $error("menu_cursor: N_ITEMS must be in 2..8");
  end

  localparam logic [HV_W-1:0] X_OUT_LO = HV_W'(X - BORDER);
  localparam logic [HV_W-1:0] X_OUT_HI = HV_W'(X + ITEM_W + BORDER - 1);
  localparam logic [HV_W-1:0] X_IN_LO  = HV_W'(X);
  localparam logic [HV_W-1:0] X_IN_HI  = HV_W'(X + ITEM_W - 1);

  logic [HV_W-1:0]  r_hcount;
  logic [HV_W-1:0]  r_vcount;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_hblnk;
  logic             r_vblnk;
  logic [RGB_B-1:0] r_rgb;

  logic [HV_W-1:0]  w_ytop;
  logic [HV_W-1:0]  w_y_out_lo;
  logic [HV_W-1:0]  w_y_out_hi;
  logic [HV_W-1:0]  w_y_in_hi;
  logic             w_in_outer;
  logic             w_in_inner;
  logic             w_overlay;
  logic             w_frame_tick;
  logic [2:0]       w_sel_idx;
  logic             w_blink_on;
  logic             w_confirmed;
  logic             w_sel_valid;

  assign w_frame_tick = vga_in.vblnk & ~r_vblnk;

  menu_cursor_ctl #(
    .N_ITEMS      (N_ITEMS),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_ctl (
    .clk        (clk),
    .rst        (rst),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_enter  (key_enter),
    .unlock     (unlock),
    .frame_tick (w_frame_tick),
    .sel_idx    (w_sel_idx),
    .blink_on   (w_blink_on),
    .confirmed  (w_confirmed),
    .sel_valid  (w_sel_valid)
  );

  // Top edge of each item is a constant per index, so this is a small LUT.
  always_comb begin
    w_ytop = HV_W'(Y);
    for (int k = 0; k < N_ITEMS; k++) begin
      if (w_sel_idx == 3'(k)) begin
        w_ytop = HV_W'(Y + k * ITEM_PITCH);
      end
    end
  end

  assign w_y_out_lo = w_ytop - HV_W'(BORDER);
  assign w_y_out_hi = w_ytop + HV_W'(ITEM_H + BORDER - 1);
  assign w_y_in_hi  = w_ytop + HV_W'(ITEM_H - 1);

  assign w_in_outer = (vga_in.hcount >= X_OUT_LO) && (vga_in.hcount <= X_OUT_HI) &&
                      (vga_in.vcount >= w_y_out_lo) && (vga_in.vcount <= w_y_out_hi);
  assign w_in_inner = (vga_in.hcount >= X_IN_LO) && (vga_in.hcount <= X_IN_HI) &&
                      (vga_in.vcount >= w_ytop) && (vga_in.vcount <= w_y_in_hi);
  assign w_overlay  = w_in_outer && !w_in_inner && (w_blink_on || w_confirmed) &&
                      !vga_in.hblnk && !vga_in.vblnk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hsync  <= 1'b0;
      r_vsync  <= 1'b0;
      r_hblnk  <= 1'b0;
      r_vblnk  <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_hcount <= vga_in.hcount;
      r_vcount <= vga_in.vcount;
      r_hsync  <= vga_in.hsync;
      r_vsync  <= vga_in.vsync;
      r_hblnk  <= vga_in.hblnk;
      r_vblnk  <= vga_in.vblnk;
      r_rgb    <= w_overlay ? FRAME_COLOR : rgb_i;
    end
  end

  assign vga_out.hcount = r_hcount;
  assign vga_out.vcount = r_vcount;
  assign vga_out.hsync  = r_hsync;
  assign vga_out.vsync  = r_vsync;
  assign vga_out.hblnk  = r_hblnk;
  assign vga_out.vblnk  = r_vblnk;
  assign rgb_o          = r_rgb;
  assign sel_idx        = w_sel_idx;
  assign sel_valid      = w_sel_valid;
  assign confirmed      = w_confirmed;

endmodule

// File: tb/tb_menu_cursor.sv
// Self-checking bench for menu_cursor: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_menu_cursor;
  import vga_pkg::*;

  localparam int         PX    = 64;
  localparam int         PY    = 48;
  localparam int         IW    = 128;
  localparam int         IH    = 16;
  localparam int         PITCH = 32;
  localparam int         NI    = 3;
  localparam int         BRD   = 2;
  localparam int         BLINK = 30;
  localparam logic [11:0] FC   = 12'hF00;
  localparam logic [11:0] BG   = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] rgbI = '0;
  logic        keyUp = 1'b0;
  logic        keyDown = 1'b0;
  logic        keyEnter = 1'b0;
  logic        unlock = 1'b0;
  logic [11:0] rgbO;
  logic [2:0]  selIdx;
  logic        selValid;
  logic        confirmed;

  int checks = 0;
  int failures = 0;

  vga_if vgaIn ();
  vga_if vgaOut ();

  always #5 clk = ~clk;

  menu_cursor #(
    .X            (PX),
    .Y            (PY),
    .ITEM_W       (IW),
    .ITEM_H       (IH),
    .ITEM_PITCH   (PITCH),
    .N_ITEMS      (NI),
    .BORDER       (BRD),
    .FRAME_COLOR  (FC),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vga_in    (vgaIn),
    .rgb_i     (rgbI),
    .key_up    (keyUp),
    .key_down  (keyDown),
    .key_enter (keyEnter),
    .unlock    (unlock),
    .vga_out   (vgaOut),
    .rgb_o     (rgbO),
    .sel_idx   (selIdx),
    .sel_valid (selValid),
    .confirmed (confirmed)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: selection, confirm flag and blink phase as plain integers.
  int  mIdx = 0;
  bit  mConf = 0;
  int  mTicks = 0;
  bit  mPrevVb = 0;
  bit  mVis;
  bit  mTick;
  bit  mMoved;
  int  eRgb = 0, eH = 0, eV = 0, eIdx = 0;
  bit  eHs = 0, eVs = 0, eHb = 0, eVb = 0, eValid = 0, eConf = 0;

  function automatic bit inFrame(input int hc, input int vc, input int idx);
    int top;
    bit outer, inner;
    top   = PY + idx * PITCH;
    outer = hc >= PX - BRD && hc <= PX + IW + BRD - 1 && vc >= top - BRD && vc <= top + IH + BRD - 1;
    inner = hc >= PX && hc <= PX + IW - 1 && vc >= top && vc <= top + IH - 1;
    return outer && !inner;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mIdx = 0; mConf = 0; mTicks = 0; mPrevVb = 0;
      eRgb = 0; eH = 0; eV = 0; eIdx = 0;
      eHs = 0; eVs = 0; eHb = 0; eVb = 0; eValid = 0; eConf = 0;
    end else begin
      mVis = ((mTicks / BLINK) % 2 == 0) || mConf;
      eRgb = (!vgaIn.hblnk && !vgaIn.vblnk && mVis &&
              inFrame(int'(vgaIn.hcount), int'(vgaIn.vcount), mIdx)) ? int'(FC) : int'(rgbI);
      eH = int'(vgaIn.hcount); eV = int'(vgaIn.vcount);
      eHs = vgaIn.hsync; eVs = vgaIn.vsync; eHb = vgaIn.hblnk; eVb = vgaIn.vblnk;
      mTick = vgaIn.vblnk && !mPrevVb;
      mPrevVb = vgaIn.vblnk;
      eValid = 0;
      mMoved = 0;
      if (!mConf) begin
        if (keyEnter) begin
          mConf = 1; eValid = 1;
        end else if (keyUp && !keyDown) begin
          mIdx = (mIdx + NI - 1) % NI; mMoved = 1;
        end else if (keyDown && !keyUp) begin
          mIdx = (mIdx + 1) % NI; mMoved = 1;
        end
      end else if (unlock) begin
        mConf = 0;
      end
      if (mMoved) mTicks = 0;
      else if (mTick) mTicks++;
      eIdx = mIdx; eConf = mConf;
    end
  end

  // Every cycle outside reset, all outputs are compared against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("rgb_o", int'(rgbO), eRgb);
      checkOutput("hcount", int'(vgaOut.hcount), eH);
      checkOutput("vcount", int'(vgaOut.vcount), eV);
      checkOutput("hsync", int'(vgaOut.hsync), int'(eHs));
      checkOutput("vsync", int'(vgaOut.vsync), int'(eVs));
      checkOutput("hblnk", int'(vgaOut.hblnk), int'(eHb));
      checkOutput("vblnk", int'(vgaOut.vblnk), int'(eVb));
      checkOutput("sel_idx", int'(selIdx), eIdx);
      checkOutput("sel_valid", int'(selValid), int'(eValid));
      checkOutput("confirmed", int'(confirmed), int'(eConf));
    end
  end

  task automatic applyStimulus(input int hc, input int vc, input bit hb, input bit vb,
                               input logic [11:0] rgb, input bit up, input bit down,
                               input bit enter, input bit unl);
    vgaIn.hcount = HV_W'(hc);
    vgaIn.vcount = HV_W'(vc);
    vgaIn.hsync  = hc[0];
    vgaIn.vsync  = vc[0];
    vgaIn.hblnk  = hb;
    vgaIn.vblnk  = vb;
    rgbI     = rgb;
    keyUp    = up;
    keyDown  = down;
    keyEnter = enter;
    unlock   = unl;
    @(posedge clk);
    #1;
    keyUp = 0; keyDown = 0; keyEnter = 0; unlock = 0;
  endtask

  task automatic tickFrames(input int n, input int vc);
    for (int i = 0; i < n; i++) begin
      applyStimulus(63, vc, 0, 1, BG, 0, 0, 0, 0);
      applyStimulus(63, vc, 0, 0, BG, 0, 0, 0, 0);
    end
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #3 rst = 1;
    #1;
    checkOutput("reset_rgb_o", int'(rgbO), 0);
    checkOutput("reset_sel_idx", int'(selIdx), 0);
    checkOutput("reset_confirmed", int'(confirmed), 0);
    checkOutput("reset_sel_valid", int'(selValid), 0);
    checkOutput("reset_hcount", int'(vgaOut.hcount), 0);
    #3 rst = 0;
  endtask

  initial begin
    bit vbState;
    vgaIn.hcount = '0; vgaIn.vcount = '0; vgaIn.hsync = 0; vgaIn.vsync = 0;
    vgaIn.hblnk = 0; vgaIn.vblnk = 0;
    #23 rst = 0;

    // Passthrough and frame edge geometry for item 0.
    applyStimulus(300, 10, 0, 0, BG, 0, 0, 0, 0);
    @(negedge clk); checkOutput("passthrough", int'(rgbO), int'(BG));
    applyStimulus(63, 48, 0, 0, BG, 0, 0, 0, 0);
    @(negedge clk); checkOutput("frame_left", int'(rgbO), int'(FC));
    applyStimulus(64, 48, 0, 0, BG, 0, 0, 0, 0);
    @(negedge clk); checkOutput("inner_box", int'(rgbO), int'(BG));
    applyStimulus(63, 48, 1, 0, BG, 0, 0, 0, 0);
    @(negedge clk); checkOutput("hblnk_no_overlay", int'(rgbO), int'(BG));

    // Cursor moves and wrap in both directions.
    applyStimulus(0, 0, 1, 0, BG, 0, 1, 0, 0);
    @(negedge clk); checkOutput("down_to_1", int'(selIdx), 1);
    applyStimulus(0, 0, 1, 0, BG, 0, 1, 0, 0);
    @(negedge clk); checkOutput("down_to_2", int'(selIdx), 2);
    applyStimulus(0, 0, 1, 0, BG, 0, 1, 0, 0);
    @(negedge clk); checkOutput("down_wrap_0", int'(selIdx), 0);
    applyStimulus(0, 0, 1, 0, BG, 1, 0, 0, 0);
    @(negedge clk); checkOutput("up_wrap_2", int'(selIdx), 2);
    applyStimulus(0, 0, 1, 0, BG, 1, 0, 0, 0);
    @(negedge clk); checkOutput("up_to_1", int'(selIdx), 1);

    // Enter wins over a simultaneous move; confirmed state ignores keys.
    applyStimulus(0, 0, 1, 0, BG, 0, 1, 1, 0);
    @(negedge clk);
    checkOutput("enter_sel_valid", int'(selValid), 1);
    checkOutput("enter_sel_idx", int'(selIdx), 1);
    checkOutput("enter_confirmed", int'(confirmed), 1);
    applyStimulus(0, 0, 1, 0, BG, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("sel_valid_one_cycle", int'(selValid), 0);
    checkOutput("confirmed_ignores_up", int'(selIdx), 1);
    applyStimulus(0, 0, 1, 0, BG, 0, 0, 0, 1);
    @(negedge clk); checkOutput("unlock", int'(confirmed), 0);

    // Blink phases from a fresh reset: on 0..29, off 30..59, on at 60.
    applyStimulus(63, 80, 0, 0, 12'h123, 0, 0, 0, 0);
    pulseReset();
    for (int n = 0; n <= 60; n++) begin
      applyStimulus(63, 48, 0, 0, BG, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("blink_phase", int'(rgbO), (n < 30 || n >= 60) ? int'(FC) : int'(BG));
      if (n == 35) begin
        applyStimulus(63, 48, 0, 0, BG, 1, 1, 0, 0);
        applyStimulus(63, 48, 0, 0, BG, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("both_keys_no_restart", int'(rgbO), int'(BG));
        checkOutput("both_keys_no_move", int'(selIdx), 0);
      end
      applyStimulus(63, 48, 0, 1, BG, 0, 0, 0, 0);
    end

    // A move in the hidden phase restarts a full visible phase.
    pulseReset();
    tickFrames(45, 80);
    applyStimulus(63, 48, 0, 0, BG, 0, 0, 0, 0);
    @(negedge clk); checkOutput("hidden_at_45", int'(rgbO), int'(BG));
    applyStimulus(63, 80, 0, 0, BG, 0, 1, 0, 0);
    applyStimulus(63, 80, 0, 0, BG, 0, 0, 0, 0);
    @(negedge clk); checkOutput("move_restarts_blink", int'(rgbO), int'(FC));
    tickFrames(29, 80);
    @(negedge clk); checkOutput("visible_29_after_move", int'(rgbO), int'(FC));
    tickFrames(1, 80);
    @(negedge clk); checkOutput("hidden_30_after_move", int'(rgbO), int'(BG));

    // Miniature raster sweep for the timing passthrough.
    for (int vc = 0; vc < 12; vc++) begin
      for (int hc = 0; hc < 50; hc++) begin
        applyStimulus(hc, vc, hc >= 40, vc >= 10, 12'(hc * 7 + vc), 0, 0, 0, 0);
      end
    end

    // Randomized traffic: sparse keys first, then dense keys.
    vbState = 0;
    for (int i = 0; i < 4500; i++) begin
      int keyRate;
      keyRate = (i < 3000) ? 40 : 6;
      if ($urandom_range(0, 2) == 0) vbState = ~vbState;
      applyStimulus($urandom_range(40, 220), $urandom_range(30, 130),
                    $urandom_range(0, 7) == 0, vbState, 12'($urandom),
                    $urandom_range(0, keyRate - 1) == 0, $urandom_range(0, keyRate - 1) == 0,
                    $urandom_range(0, keyRate * 2 - 1) == 0, $urandom_range(0, keyRate - 1) == 0);
      if (i == 3500) pulseReset();
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
